// File: rtl/mult_seq_16bit_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// operand width, iteration count and FSM state encoding.
package mult_seq_16bit_pkg;

  localparam int OP_W      = 16;
  localparam int MULT_ITER = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_seq_16bit_cla.sv
// 16-bit carry-lookahead adder: four 4-bit groups with lookahead
// between groups; bits inside a group take their carry from the group carry.
module mult_seq_16bit_cla (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [3:0]  gg;
  logic [3:0]  pg;
  logic [4:0]  gc;
  logic [15:0] c;

  // Generate/propagate terms, group lookahead, then per-bit carries and sum.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later lines see the
    // values computed earlier in the same pass.
    g = a & b;
    p = a ^ b;
    // NOTE: every output of this block gets a default before any
    // conditional or loop, so no path can leave it unassigned (no latch).
    gg = '0;
    pg = '1;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        pg[k] = pg[k] & p[4*k+j];
      end
    end
    gc[0] = cin;
    gc[1] = gg[0] | (pg[0] & cin);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & cin);
    gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0])
          | (pg[3] & pg[2] & pg[1] & pg[0] & cin);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/mult_seq_16bit.sv
// Sequential 16x16 -> 32 shift-and-add multiplier, signed or unsigned,
// with start/busy/done handshake and a fixed 18-cycle latency.
module mult_seq_16bit
  import mult_seq_16bit_pkg::*;
#(
  parameter int WIDTH = OP_W,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P,
  output logic               ovf
);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sop_q;
  logic               neg;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   hi_a;
  logic [WIDTH-1:0]   hi_b;
  logic               hi_cin;
  logic [WIDTH-1:0]   hi_sum;
  logic               hi_co;
  logic [WIDTH-1:0]   lo_sum;
  logic               lo_co;
  logic               calc_c;
  logic [WIDTH-1:0]   calc_sum;
  logic [2*WIDTH-1:0] result;
  logic               ovf_next;

  // Magnitudes of the latched operands; 0x8000 maps to itself as unsigned.
  assign a_mag = (sop_q & a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
  assign b_mag = (sop_q & b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

  // Low half of the final negation: ~acc_lo + 1.
  mult_seq_16bit_cla u_add_lo (
    .a    (~acc_lo),
    .b    ('0),
    .cin  (1'b1),
    .sum  (lo_sum),
    .cout (lo_co)
  );

  // The high adder does the partial-product add in CALC and the upper
  // half of the negation (carry from the low half) in FIX.
  always_comb begin
    hi_a   = acc_hi;
    hi_b   = mcand;
    hi_cin = 1'b0;
    if (state == FIX) begin
      hi_a   = ~acc_hi;
      hi_b   = '0;
      hi_cin = lo_co;
    end
  end

  mult_seq_16bit_cla u_add_hi (
    .a    (hi_a),
    .b    (hi_b),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (hi_co)
  );

  // Partial-product step: carry kept as the 17th bit of the sum.
  assign calc_c   = acc_lo[0] ? hi_co  : 1'b0;
  assign calc_sum = acc_lo[0] ? hi_sum : acc_hi;

  // Final product, sign-corrected, and its overflow flag.
  assign result   = neg ? {hi_sum, lo_sum} : {acc_hi, acc_lo};
  assign ovf_next = sop_q ? !((&result[2*WIDTH-1:WIDTH-1]) || !(|result[2*WIDTH-1:WIDTH-1]))
                          : (|result[2*WIDTH-1:WIDTH]);

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sop_q  <= 1'b0;
      neg    <= 1'b0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      P      <= '0;
      ovf    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples pre-edge values, independent of statement order.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            sop_q <= signed_op;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          mcand  <= a_mag;
          acc_hi <= '0;
          acc_lo <= b_mag;
          neg    <= sop_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          cnt    <= '0;
          state  <= CALC;
        end
        CALC: begin
          acc_hi <= {calc_c, calc_sum[WIDTH-1:1]};
          acc_lo <= {calc_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(MULT_ITER - 1)) state <= FIX;
        end
        FIX: begin
          P     <= result;
          ovf   <= ovf_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
